// File: rtl/rs232_slip_pkg.sv
// Shared SLIP constants, decoder state encoding and the output beat type
// used by rs232_slip_rx and its output register slice.
package rs232_slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ESC  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    typedef struct packed {
        logic       last;
        logic       err;
        logic [7:0] data;
    } slip_beat_t;

endpackage

// File: rtl/rs232_slip_rx_if.sv
// Bundles the rs232_rxb FIFO read side and the decoded byte stream.
// master: the decoder. slave: FIFO plus stream consumer.
interface rs232_slip_rx_if;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_rd;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic       dout_err;

    modport master (
        input  rx_data, rx_empty, dout_ready,
        output rx_rd, dout, dout_valid, dout_last, dout_err
    );

    modport slave (
        output rx_data, rx_empty, dout_ready,
        input  rx_rd, dout, dout_valid, dout_last, dout_err
    );
endinterface

// File: rtl/rs232_slip_rx_stream_reg.sv
// Output register slice for the decoded stream: holds data/last/err stable
// while valid and not ready; a load always takes priority over emptying.
module rs232_slip_rx_stream_reg
    import rs232_slip_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  slip_beat_t load_beat,
    input  logic       ready,
    output logic       valid,
    output slip_beat_t beat
);

    logic       valid_q, valid_d;
    slip_beat_t beat_q,  beat_d;

    // Next slice contents: reload, clear on handshake, or hold.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load) begin
            valid_d = 1'b1;
            beat_d  = load_beat;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
            beat_d  = '0;
        end
    end

    // Slice registers, emptied by reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples the pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign valid = valid_q;
    assign beat  = beat_q;

endmodule

// File: rtl/rs232_slip_rx.sv
// SLIP frame decoder behind the rs232_rxb FIFO. Strips END framing and ESC
// sequences, delays each byte in a one-byte hold so the final byte can be
// tagged last, and aborts frames on bad escapes or overlength.
// Optional: define RS232_SLIP_CNT_EN for saturating frame/error counters.
module rs232_slip_rx
    import rs232_slip_pkg::*;
#(
    parameter int max_len   = 1024,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rs232_slip_rx_if.master      bus,
    output logic                 frame_err,
    output logic [cnt_width-1:0] frame_cnt,
    output logic [cnt_width-1:0] err_cnt
);

    localparam int LEN_W = $clog2(max_len + 1);

    logic [1:0]       state_q, state_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             frame_err_q, frame_err_d;

    logic       pop;
    logic       load;
    slip_beat_t load_beat;
    logic       out_valid;
    slip_beat_t out_beat;
    logic       dec_valid;
    logic [7:0] dec_byte;
    logic       bad;

    // Pop only when the out stage can take whatever this byte may release; never during reset.
    assign pop       = ~rst & ~bus.rx_empty & (~out_valid | bus.dout_ready);
    assign bus.rx_rd = pop;

    // Decode the popped byte: framing/escape handling, hold shuffling and error abort.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        len_d        = len_q;
        frame_err_d  = 1'b0;
        load         = 1'b0;
        load_beat    = '0;
        dec_valid    = 1'b0;
        dec_byte     = '0;
        bad          = 1'b0;

        if (pop) begin
            case (state_q)
                ST_HUNT: if (bus.rx_data == SLIP_END) state_d = ST_DATA;
                ST_DATA: begin
                    if (bus.rx_data == SLIP_END) begin
                        // Close the frame; an empty frame produces nothing.
                        if (hold_valid_q) begin
                            load      = 1'b1;
                            load_beat = '{last: 1'b1, err: 1'b0, data: hold_data_q};
                        end
                        hold_valid_d = 1'b0;
                        len_d        = '0;
                    end else if (bus.rx_data == SLIP_ESC) begin
                        state_d = ST_ESC;
                    end else begin
                        dec_valid = 1'b1;
                        dec_byte  = bus.rx_data;
                    end
                end
                ST_ESC: begin
                    state_d = ST_DATA;
                    if (bus.rx_data == SLIP_ESC_END) begin
                        dec_valid = 1'b1;
                        dec_byte  = SLIP_END;
                    end else if (bus.rx_data == SLIP_ESC_ESC) begin
                        dec_valid = 1'b1;
                        dec_byte  = SLIP_ESC;
                    end else begin
                        // An END here has already re-opened framing, so only other bytes need DROP.
                        bad = 1'b1;
                        if (bus.rx_data != SLIP_END) state_d = ST_DROP;
                    end
                end
                default: if (bus.rx_data == SLIP_END) state_d = ST_DATA;
            endcase
        end

        if (dec_valid) begin
            if (len_q == LEN_W'(max_len)) begin
                bad     = 1'b1;
                state_d = ST_DROP;
            end else begin
                if (hold_valid_q) begin
                    load      = 1'b1;
                    load_beat = '{last: 1'b0, err: 1'b0, data: hold_data_q};
                end
                hold_valid_d = 1'b1;
                hold_data_d  = dec_byte;
                len_d        = len_q + LEN_W'(1);
            end
        end

        if (bad) begin
            frame_err_d  = 1'b1;
            len_d        = '0;
            hold_valid_d = 1'b0;
            load         = hold_valid_q;
            load_beat    = '{last: 1'b1, err: 1'b1, data: hold_data_q};
        end
    end

    // Decoder state, hold register, length and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            len_q        <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            len_q        <= len_d;
            frame_err_q  <= frame_err_d;
        end
    end

    rs232_slip_rx_stream_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_beat (load_beat),
        .ready     (bus.dout_ready),
        .valid     (out_valid),
        .beat      (out_beat)
    );

    assign bus.dout       = out_beat.data;
    assign bus.dout_valid = out_valid;
    assign bus.dout_last  = out_beat.last;
    assign bus.dout_err   = out_beat.err;
    assign frame_err      = frame_err_q;

`ifdef RS232_SLIP_CNT_EN
    logic [cnt_width-1:0] frame_cnt_q, frame_cnt_d;
    logic [cnt_width-1:0] err_cnt_q, err_cnt_d;

    // Saturating counts of good frames handed off and of detected frame errors.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (out_valid && bus.dout_ready && out_beat.last && !out_beat.err && (frame_cnt_q != '1))
            frame_cnt_d = frame_cnt_q + cnt_width'(1);
        if (frame_err_d && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + cnt_width'(1);
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_rs232_slip_rx.sv
// Bench for rs232_slip_rx: FIFO model on the read side, frame-level SLIP
// reference decoder, directed cases plus randomized frames.
// Counter expectations follow RS232_SLIP_CNT_EN.
module tb_rs232_slip_rx;

    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 16;
`ifdef RS232_SLIP_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic             clk;
    logic             rst;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    rs232_slip_rx_if bus ();

    rs232_slip_rx #(.max_len(MAX_LEN), .cnt_width(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [9:0] log_q[$];
    logic [7:0] frame_buf[$];
    bit         m_hunting = 1'b1;
    int         m_frames  = 0;
    int         m_errs    = 0;
    int         pulse_cnt = 0;
    bit         rd_sampled = 1'b0;
    bit         rand_ready = 1'b0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_item  = '0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame-level reference: decode the bytes between two ENDs (or up to a reset).
    function automatic void decode_frame(input logic [7:0] fr[$], input bit complete);
        logic [7:0] d[$];
        bit err  = 1'b0;
        bit stop = 1'b0;
        for (int i = 0; i < fr.size() && !stop; i++) begin
            logic [7:0] v;
            v = fr[i];
            if (v == 8'hDB) begin
                if (i + 1 >= fr.size()) begin
                    err  = complete;
                    stop = 1'b1;
                    continue;
                end
                i++;
                if (fr[i] == 8'hDC)      v = 8'hC0;
                else if (fr[i] == 8'hDD) v = 8'hDB;
                else begin
                    err  = 1'b1;
                    stop = 1'b1;
                    continue;
                end
            end
            if (d.size() == MAX_LEN) begin
                err  = 1'b1;
                stop = 1'b1;
                continue;
            end
            d.push_back(v);
        end
        if (!complete && !err) return;
        if (err) m_errs++;
        else if (d.size() > 0) m_frames++;
        for (int k = 0; k < d.size(); k++)
            exp_q.push_back({k == d.size() - 1, err && (k == d.size() - 1), d[k]});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_hunting) begin
            if (b == 8'hC0) m_hunting = 1'b0;
        end else if (b == 8'hC0) begin
            decode_frame(frame_buf, 1'b1);
            frame_buf.delete();
        end else begin
            frame_buf.push_back(b);
        end
    endfunction

    function automatic void model_reset();
        if (!m_hunting) decode_frame(frame_buf, 1'b0);
        frame_buf.delete();
        exp_q.delete();
        m_hunting = 1'b1;
        m_frames  = 0;
        m_errs    = 0;
    endfunction

    task automatic drive_fifo();
        bus.rx_empty = (fifo_q.size() == 0);
        bus.rx_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        drive_fifo();
    endtask

    // One clock: retire the byte popped at this edge, then update inputs.
    task automatic tick();
        logic [7:0] b;
        @(posedge clk);
        #1;
        if (rd_sampled && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            model_byte(b);
        end
        if (rand_ready) bus.dout_ready = ($urandom_range(0, 99) < 70);
        drive_fifo();
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int k = 0;
        while ((fifo_q.size() != 0 || bus.dout_valid) && k < max_cycles) begin
            tick();
            k++;
        end
        check({tag, "_drain"}, int'(fifo_q.size() == 0 && !bus.dout_valid), 1);
        repeat (3) tick();
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_unexpected_out"}, got_q.size(), 0);
        check({tag, "_missing_out"}, exp_q.size(), 0);
        check({tag, "_frame_cnt"}, int'(frame_cnt), CNT_ON * m_frames);
        check({tag, "_err_cnt"}, int'(err_cnt), CNT_ON * m_errs);
        check({tag, "_frame_err_pulses"}, pulse_cnt, m_errs);
    endtask

    task automatic check_log(input string tag, input logic [9:0] lit[$]);
        check({tag, "_beats"}, log_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < log_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), int'(log_q[i]), int'(lit[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.dout_valid), 0);
        check({tag, "_dout"}, int'(bus.dout), 0);
        check({tag, "_last"}, int'(bus.dout_last), 0);
        check({tag, "_err"}, int'(bus.dout_err), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_rx_rd"}, int'(bus.rx_rd), 0);
        check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // Output monitor on the falling edge: pop rule, stability, stream order vs model.
    always @(negedge clk) begin
        logic [9:0] item;
        logic [9:0] g;
        logic [9:0] e;
        item       = {bus.dout_last, bus.dout_err, bus.dout};
        rd_sampled = bus.rx_rd;
        if (!rst) begin
            check("rx_rd_rule", int'(bus.rx_rd),
                  int'(!bus.rx_empty && (!bus.dout_valid || bus.dout_ready)));
            if (bus.dout_valid) check("err_without_last", int'(bus.dout_err && !bus.dout_last), 0);
            if (prev_stall) check("stall_stable", int'({bus.dout_valid, item}), int'({1'b1, prev_item}));
            if (frame_err) pulse_cnt++;
            if (bus.dout_valid && bus.dout_ready) begin
                got_q.push_back(item);
                log_q.push_back(item);
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                check("stream", int'(g), int'(e));
            end
        end
        prev_stall = !rst && bus.dout_valid && !bus.dout_ready;
        prev_item  = item;
    end

    task automatic gen_frame();
        int n;
        int r;
        logic [7:0] b;
        n = $urandom_range(0, 7);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 19);
            if (r < 14) begin
                do b = 8'($urandom); while (b == 8'hC0 || b == 8'hDB);
                fifo_q.push_back(b);
            end else if (r < 16) begin
                fifo_q.push_back(8'hDB); fifo_q.push_back(8'hDC);
            end else if (r < 18) begin
                fifo_q.push_back(8'hDB); fifo_q.push_back(8'hDD);
            end else if (r == 18) begin
                do b = 8'($urandom); while (b == 8'hDC || b == 8'hDD || b == 8'hC0);
                fifo_q.push_back(8'hDB); fifo_q.push_back(b);
            end else begin
                fifo_q.push_back(8'hDB);
                break;
            end
        end
        fifo_q.push_back(8'hC0);
        drive_fifo();
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [9:0] lit[$];

        rst            = 1'b1;
        bus.dout_ready = 1'b1;
        bus.rx_empty   = 1'b1;
        bus.rx_data    = 8'h00;

        // 1: bytes before the first END are discarded.
        seq = '{8'h55, 8'hC0, 8'h01, 8'h02, 8'hC0};
        push_bytes(seq);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        log_q.delete();
        wait_drain("t1", 200);
        lit = '{10'h001, 10'h202};
        check_log("t1", lit);
        check("t1_frame_cnt_lit", int'(frame_cnt), CNT_ON);
        checkpoint("t1");

        // 2: escapes.
        log_q.delete();
        seq = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h7E, 8'hC0};
        push_bytes(seq);
        wait_drain("t2", 200);
        lit = '{10'h0C0, 10'h0DB, 10'h27E};
        check_log("t2", lit);
        checkpoint("t2");

        // 3: bad escape aborts, rest of frame dropped, next frame fine.
        log_q.delete();
        seq = '{8'hC0, 8'h10, 8'hDB, 8'h33, 8'h20, 8'hC0, 8'hC0, 8'h05, 8'hC0};
        push_bytes(seq);
        wait_drain("t3", 200);
        lit = '{10'h310, 10'h205};
        check_log("t3", lit);
        check("t3_err_cnt_lit", int'(err_cnt), CNT_ON);
        checkpoint("t3");

        // 4: overlength with max_len=4.
        log_q.delete();
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC0};
        push_bytes(seq);
        wait_drain("t4", 200);
        lit = '{10'h001, 10'h002, 10'h003, 10'h304};
        check_log("t4", lit);
        checkpoint("t4");

        // 5: empty frames, then stall with the out stage full.
        log_q.delete();
        bus.dout_ready = 1'b0;
        seq = '{8'hC0, 8'hC0, 8'hC0, 8'hAA, 8'hC0, 8'hBB, 8'hC0};
        push_bytes(seq);
        repeat (6) tick();
        for (int i = 0; i < 10; i++) begin
            check("t5_hold", int'({bus.dout_valid, bus.dout_last, bus.dout_err, bus.dout}),
                  int'({1'b1, 10'h2AA}));
            check("t5_no_pop", int'(bus.rx_rd), 0);
            tick();
        end
        bus.dout_ready = 1'b1;
        wait_drain("t5", 200);
        lit = '{10'h2AA, 10'h2BB};
        check_log("t5", lit);
        checkpoint("t5");

        // 6: reset mid-frame while the out stage is stalled.
        log_q.delete();
        bus.dout_ready = 1'b0;
        seq = '{8'hC0, 8'h11, 8'h22};
        push_bytes(seq);
        repeat (6) tick();
        check("t6_pre_reset", int'({bus.dout_valid, bus.dout}), int'({1'b1, 8'h11}));
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        model_reset();
        pulse_cnt = 0;
        repeat (2) tick();
        rst            = 1'b0;
        bus.dout_ready = 1'b1;
        seq = '{8'h33, 8'hC0, 8'h44, 8'hC0};
        push_bytes(seq);
        wait_drain("t6", 200);
        lit = '{10'h244};
        check_log("t6", lit);
        checkpoint("t6");

        // Randomized frames with random back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            for (int f = 0; f < 6; f++) gen_frame();
            wait_drain($sformatf("rnd%0d", r), 4000);
            checkpoint($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
